// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the one-hot-write register file.
//   DEF_ADDR_W / DEF_DATA_W : default address and data widths
//   depth_of(addr_w)        : number of registers addressed by addr_w bits
package regfile_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  // Register count for a given address width.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/regfile_onehot_wr_if.sv
// Bus bundle for regfile_onehot_wr: one write port, two read ports,
// the registered write-select trace and the branch-equality flag.
//   master : drives write/read requests, observes read data, trace and compare
//   slave  : the register file side
interface regfile_onehot_wr_if
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DEPTH-1:0]  wr_sel_q;
  logic              a_eq_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_sel_q, a_eq_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_sel_q, a_eq_b
  );

endinterface

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable.
//   addr : binary index, ADDR_W bits
//   en   : when low the output is all-zero (never a stale select)
//   sel  : 2**ADDR_W bit one-hot vector, bit addr set when en is high
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  localparam int unsigned DEPTH  = depth_of(ADDR_W)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  sel
);

  // Shift of a single set bit; DEPTH = 2**ADDR_W so the top address lands on the MSB.
  assign sel = en ? (DEPTH'(1) << addr) : '0;

endmodule

// File: rtl/regfile_onehot_wr.sv
// Parametrised register file with one-hot gated writes.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears storage and wr_sel_q
//   bus   : regfile_onehot_wr_if.slave
//     wr_en/wr_addr/wr_data    write request, applied at posedge clk
//     rd_addr_a/rd_addr_b      read addresses
//     rd_data_a/rd_data_b      combinational read data (optional bypass)
//     wr_sel_q                 registered one-hot select of the last accepted write
//     a_eq_b                   combinational rd_data_a == rd_data_b
// ZERO_REG = 1 hardwires register 0 to zero; BYPASS = 1 forwards same-cycle
// write data to a matching read port.
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                clk,
  input logic                reset,
  regfile_onehot_wr_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0]  sel;
  logic [DEPTH-1:0]  sel_m;
  logic              zero_hit;
  logic              wr_fire;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_sel_r;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr (bus.wr_addr),
    .en   (bus.wr_en),
    .sel  (sel)
  );

  // Writes to a hardwired register 0 are dropped here, so neither storage,
  // trace nor bypass ever sees them.
  always_comb begin
    zero_hit = ZERO_REG && (bus.wr_addr == '0);
    sel_m    = zero_hit ? '0 : sel;
    wr_fire  = |sel_m;
  end

  // Storage: each register loads only on its own select bit.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem[i] <= '0;
      end else if (sel_m[i]) begin
        mem[i] <= bus.wr_data;
      end
    end
  end

  // Debug trace of the last accepted write; all-zero after an idle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sel_r <= '0;
    end else begin
      wr_sel_r <= sel_m;
    end
  end

  // Read port A: stored value, then bypass, then zero-register override.
  always_comb begin
    rd_a = mem[bus.rd_addr_a];
    if (BYPASS && wr_fire && (bus.rd_addr_a == bus.wr_addr)) begin
      rd_a = bus.wr_data;
    end
    if (ZERO_REG && (bus.rd_addr_a == '0)) begin
      rd_a = '0;
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rd_b = mem[bus.rd_addr_b];
    if (BYPASS && wr_fire && (bus.rd_addr_b == bus.wr_addr)) begin
      rd_b = bus.wr_data;
    end
    if (ZERO_REG && (bus.rd_addr_b == '0)) begin
      rd_b = '0;
    end
  end

  assign bus.rd_data_a = rd_a;
  assign bus.rd_data_b = rd_b;
  assign bus.a_eq_b    = (rd_a == rd_b);
  assign bus.wr_sel_q  = wr_sel_r;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed bench for regfile_onehot_wr. Three instances:
//   dut_a : 5/32, ZERO_REG=1, BYPASS=1
//   dut_b : 5/32, ZERO_REG=0, BYPASS=0
//   dut_c : 3/8,  ZERO_REG=1, BYPASS=1
// Expected values are queued when stimulus is applied and popped in order
// when the corresponding output is sampled.
module tb_regfile_onehot_wr;

  logic clk;
  logic reset;

  regfile_onehot_wr_if #(.ADDR_W(5), .DATA_W(32)) ia ();
  regfile_onehot_wr_if #(.ADDR_W(5), .DATA_W(32)) ib ();
  regfile_onehot_wr_if #(.ADDR_W(3), .DATA_W(8))  ic ();

  regfile_onehot_wr #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  regfile_onehot_wr #(.ADDR_W(5), .DATA_W(32), .ZERO_REG(1'b0), .BYPASS(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  regfile_onehot_wr #(.ADDR_W(3), .DATA_W(8), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_c (.clk(clk), .reset(reset), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_underflow observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Same request to the two 5/32 instances.
  task automatic drv(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb);
    ia.wr_en = en; ia.wr_addr = wa; ia.wr_data = wd; ia.rd_addr_a = ra; ia.rd_addr_b = rb;
    ib.wr_en = en; ib.wr_addr = wa; ib.wr_data = wd; ib.rd_addr_a = ra; ib.rd_addr_b = rb;
  endtask

  task automatic drvc(input logic en, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb);
    ic.wr_en = en; ic.wr_addr = wa; ic.wr_data = wd; ic.rd_addr_a = ra; ic.rd_addr_b = rb;
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    drvc(1'b0, 3'd0, 8'h0, 3'd0, 3'd0);

    // Reset state
    cyc();
    expect_v("rst_a_rd_a", 32'h0);
    expect_v("rst_a_rd_b_r5", 32'h0);
    expect_v("rst_a_sel", 32'h0);
    expect_v("rst_b_sel", 32'h0);
    expect_v("rst_c_sel", 32'h0);
    expect_v("rst_a_eq", 32'h1);
    observe(ia.rd_data_a);
    observe(ia.rd_data_b);
    observe(ia.wr_sel_q);
    observe(ib.wr_sel_q);
    observe(32'(ic.wr_sel_q));
    observe(32'(ia.a_eq_b));
    reset = 1'b0;

    // Basic write to r31 (top address), read A=r31 B=r0
    drv(1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd0);
    #1;
    expect_v("wr31_a_bypass", 32'h1234_5678);
    expect_v("wr31_b_nobypass", 32'h0);
    expect_v("wr31_a_eq_same_cycle", 32'h0);
    expect_v("wr31_b_eq_same_cycle", 32'h1);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    observe(32'(ia.a_eq_b));
    observe(32'(ib.a_eq_b));
    cyc();
    drv(1'b0, 5'd31, 32'h0, 5'd31, 5'd0);
    #1;
    expect_v("rd31_a", 32'h1234_5678);
    expect_v("rd31_b", 32'h1234_5678);
    expect_v("rd0_a", 32'h0);
    expect_v("sel31_a", 32'h8000_0000);
    expect_v("sel31_b", 32'h8000_0000);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    observe(ia.rd_data_b);
    observe(ia.wr_sel_q);
    observe(ib.wr_sel_q);
    cyc();
    expect_v("sel_idle_a", 32'h0);
    observe(ia.wr_sel_q);

    // Zero register: write all-ones to r0
    drv(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd31);
    #1;
    expect_v("r0_a_same_cycle", 32'h0);
    expect_v("r0_b_same_cycle", 32'h0);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    cyc();
    drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
    #1;
    expect_v("r0_a_hardwired", 32'h0);
    expect_v("r0_a_sel_masked", 32'h0);
    expect_v("r0_a_r31_kept", 32'h1234_5678);
    expect_v("r0_b_ordinary", 32'hFFFF_FFFF);
    expect_v("r0_b_sel", 32'h0000_0001);
    observe(ia.rd_data_a);
    observe(ia.wr_sel_q);
    observe(ia.rd_data_b);
    observe(ib.rd_data_a);
    observe(ib.wr_sel_q);

    // Bypass: r7 = 0xA, then write 0xB while reading r7
    drv(1'b1, 5'd7, 32'hA, 5'd0, 5'd0);
    cyc();
    drv(1'b1, 5'd7, 32'hB, 5'd7, 5'd0);
    #1;
    expect_v("byp_a_same_cycle", 32'hB);
    expect_v("byp_b_old_value", 32'hA);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    cyc();
    drv(1'b0, 5'd7, 32'hC, 5'd7, 5'd0);
    #1;
    expect_v("byp_a_next", 32'hB);
    expect_v("byp_b_next", 32'hB);
    expect_v("byp_a_wr_en_low", 32'hB);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    observe(ia.rd_data_a);

    // Branch equality: r3 = r4 = 0x55, then r4 = 0x56
    drv(1'b1, 5'd3, 32'h55, 5'd0, 5'd0);
    cyc();
    drv(1'b1, 5'd4, 32'h55, 5'd0, 5'd0);
    cyc();
    drv(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1;
    expect_v("eq_a_equal", 32'h1);
    expect_v("eq_b_equal", 32'h1);
    observe(32'(ia.a_eq_b));
    observe(32'(ib.a_eq_b));
    drv(1'b1, 5'd4, 32'h56, 5'd3, 5'd4);
    #1;
    expect_v("eq_a_bypass_diff", 32'h0);
    expect_v("eq_b_still_equal", 32'h1);
    observe(32'(ia.a_eq_b));
    observe(32'(ib.a_eq_b));
    cyc();
    drv(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1;
    expect_v("eq_a_diff", 32'h0);
    expect_v("eq_b_diff", 32'h0);
    expect_v("eq_b_r4", 32'h56);
    observe(32'(ia.a_eq_b));
    observe(32'(ib.a_eq_b));
    observe(ib.rd_data_b);

    // Back-to-back writes to r9: last write wins
    drv(1'b1, 5'd9, 32'h1, 5'd9, 5'd0);
    cyc();
    drv(1'b1, 5'd9, 32'h2, 5'd9, 5'd0);
    cyc();
    drv(1'b0, 5'd9, 32'hFF, 5'd9, 5'd9);
    #1;
    expect_v("b2b_a", 32'h2);
    expect_v("b2b_b", 32'h2);
    expect_v("b2b_a_same_ports", 32'h2);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    observe(ia.rd_data_b);

    // Reset between edges
    drv(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    cyc();
    drv(1'b0, 5'd5, 32'h0, 5'd5, 5'd0);
    #1;
    expect_v("pre_rst_r5", 32'hDEAD_BEEF);
    expect_v("pre_rst_sel", 32'h0000_0020);
    observe(ia.rd_data_a);
    observe(ia.wr_sel_q);
    #1;
    reset = 1'b1;
    #1;
    expect_v("rst_async_r5_a", 32'h0);
    expect_v("rst_async_sel_a", 32'h0);
    expect_v("rst_async_r5_b", 32'h0);
    observe(ia.rd_data_a);
    observe(ia.wr_sel_q);
    observe(ib.rd_data_a);
    drv(1'b1, 5'd6, 32'h77, 5'd0, 5'd0);
    cyc();
    drv(1'b0, 5'd0, 32'h0, 5'd6, 5'd31);
    #1;
    expect_v("rst_wr_discard_a", 32'h0);
    expect_v("rst_wr_discard_b", 32'h0);
    expect_v("rst_r31_a", 32'h0);
    expect_v("rst_sel_hold_a", 32'h0);
    observe(ia.rd_data_a);
    observe(ib.rd_data_a);
    observe(ia.rd_data_b);
    observe(ia.wr_sel_q);
    reset = 1'b0;

    // 3/8 instance: walk writes over addresses 1..7
    for (int i = 1; i < 8; i++) begin
      drvc(1'b1, 3'(i), 8'(i + 1), 3'd0, 3'd0);
      cyc();
      expect_v($sformatf("c_sel_walk_%0d", i), 32'(1) << i);
      observe(32'(ic.wr_sel_q));
    end
    drvc(1'b0, 3'd0, 8'h0, 3'd0, 3'd0);
    cyc();
    expect_v("c_sel_idle", 32'h0);
    observe(32'(ic.wr_sel_q));
    for (int i = 0; i < 8; i++) begin
      drvc(1'b0, 3'd0, 8'h0, 3'(i), 3'(7 - i));
      #1;
      expect_v($sformatf("c_rd_a_%0d", i), (i == 0) ? 32'h0 : 32'(i + 1));
      expect_v($sformatf("c_rd_b_%0d", 7 - i), (i == 7) ? 32'h0 : 32'(8 - i));
      observe(32'(ic.rd_data_a));
      observe(32'(ic.rd_data_b));
    end

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
